audio_dac_serializer: RTL and testbench
=======================================

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 Parameter BCLK_DIV, default 8: clock50 cycles per half bit-clock period; legal range 2..64.
REQ-002 Parameter SLOT_BITS, default 32: bit-clock periods per channel slot; fixed at 32.
REQ-003 clock50  in  1  system clock, 50 MHz; all logic is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  serializer enable; sampled every clock50 cycle.
REQ-006 sample_in  in  16  signed 2's-complement mono sample from the note synthesizer.
REQ-007 vol_shift  in  3  attenuation, applied as an arithmetic right shift of 0..7.
REQ-008 mute  in  1  when high, forces the transmitted sample to 0.
REQ-009 aud_bclk  out  1  I2S bit clock to the codec.
REQ-010 aud_daclrck  out  1  frame clock (low = left, high = right); also drives the synthesizer's sample-rate input.
REQ-011 aud_dacdat  out  1  serial I2S data, MSB first.
REQ-012 frame_start  out  1  one-cycle pulse on the cycle sample_in is captured.

Function
REQ-013 The block SHALL implement a two-state FSM:
- IDLE -> RUN when en = 1.
- RUN -> IDLE only at a frame boundary (end of the right slot) with en = 0.

REQ-014 In IDLE, the block SHALL hold aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0, and all counters at 0.

REQ-015 On the cycle it enters RUN, and at every subsequent frame boundary, the block SHALL:
- capture proc = mute ? 0 : (sample_in >>> vol_shift) into a 16-bit hold register;
- assert frame_start for exactly that cycle.

REQ-016 A divider counter SHALL count 0..BCLK_DIV-1 in RUN; aud_bclk SHALL toggle on each wrap, giving a bit-clock period of 2*BCLK_DIV clock50 cycles.

REQ-017 A slot counter SHALL advance 0..31 on each aud_bclk falling edge; aud_daclrck SHALL toggle when the slot counter wraps from 31 to 0.

REQ-018 Frame period SHALL be 64 bit clocks = 128*BCLK_DIV clock50 cycles; with the default this is 1024 cycles (48.828 kHz).

REQ-019 aud_dacdat SHALL change only on aud_bclk falling edges (or the RUN entry cycle), using the I2S one-bit delay:
- slot 0: 0;
- slots 1..16: hold[15] down to hold[0];
- slots 17..31: 0.

REQ-020 Left and right slots SHALL carry the same held sample (mono duplication).

REQ-021 Changes of sample_in, vol_shift or mute mid-frame SHALL NOT affect the frame in flight.

REQ-022 vol_shift = 7 with sample_in = 16'h8000 SHALL yield 16'hFF00 (sign preserved, no saturation needed).

REQ-023 When en falls mid-frame, the current frame SHALL complete fully; IDLE is entered on the cycle the right slot's counter wraps.

REQ-024 When en rises again, the first frame SHALL begin with a left slot and a fresh capture.

Reset
REQ-025 While reset_n = 0, the block SHALL force:
- FSM = IDLE;
- all counters and the hold register = 0;
- aud_bclk, aud_daclrck, aud_dacdat, frame_start = 0.

REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no glitch pulse on aud_bclk beyond the asynchronous drop to 0.

REQ-027 After reset_n rises, RUN SHALL be entered on the first clock50 edge with en = 1.

Structure
REQ-028 A shared package audio_pkg SHALL hold:
- the FSM state enum (IDLE, RUN);
- SAMPLE_W = 16;
- SLOT_BITS = 32;
- default BCLK_DIV = 8.

REQ-029 The block SHALL use one sub-module, audio_clkgen, containing the divider counter, aud_bclk and the fall-edge strobe.
REQ-030 The slot counter, aud_daclrck, shift register and FSM SHALL remain in audio_dac_serializer.

Verification
REQ-031 Reset release with en = 1 and sample_in = 16'h8001 SHALL produce:
- frame_start at cycle 0;
- left and right slots 1..16 = 1000_0000_0000_0001;
- zeros elsewhere.
REQ-032 Timing check, default parameters:
- aud_bclk period = 16 cycles;
- aud_daclrck period = 1024 cycles;
- frame_start spacing = 1024 cycles;
- aud_dacdat transitions only on aud_bclk falling edges.
REQ-033 sample_in = 16'h7FFF with vol_shift = 3 SHALL transmit 16'h0FFF; then mute = 1 SHALL transmit 16'h0000 from the next frame onward.
REQ-034 Toggling sample_in every 100 cycles mid-frame SHALL leave the serialized word equal to the value present at frame_start.
REQ-035 en dropped at cycle 300 of a frame SHALL give:
- outputs idle from cycle 1024 onward;
- en re-raised at cycle 2000 restarts with the left slot and frame_start the same cycle.
REQ-036 reset_n pulsed low at cycle 700 SHALL drive all outputs to 0 asynchronously; normal frames resume after release.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants, FSM state type and sample attenuation helper for the I2S DAC serializer.
package audio_pkg;
  localparam int SAMPLE_W         = 16;
  localparam int SLOT_BITS        = 32;
  localparam int BCLK_DIV_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Arithmetic shift keeps the sign, so full-scale negative input never wraps.
  function automatic logic [SAMPLE_W-1:0] attenuate(
    input logic [SAMPLE_W-1:0] sample,
    input logic [2:0]          shift,
    input logic                mute
  );
    logic signed [SAMPLE_W-1:0] shifted;
    shifted = $signed(sample) >>> shift;
    return mute ? '0 : $unsigned(shifted);
  endfunction
endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample/control inputs from the synthesizer and I2S outputs to the codec.
interface audio_dac_serializer_if;
  import audio_pkg::*;

  logic                en;
  logic [SAMPLE_W-1:0] sample_in;
  logic [2:0]          vol_shift;
  logic                mute;
  logic                aud_bclk;
  logic                aud_daclrck;
  logic                aud_dacdat;
  logic                frame_start;

  modport master (
    output en, sample_in, vol_shift, mute,
    input  aud_bclk, aud_daclrck, aud_dacdat, frame_start
  );

  modport slave (
    input  en, sample_in, vol_shift, mute,
    output aud_bclk, aud_daclrck, aud_dacdat, frame_start
  );
endinterface

// File: rtl/audio_clkgen.sv
// Bit-clock generator: divides clock50 into aud_bclk and flags the cycle before each falling edge.
module audio_clkgen
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEFAULT
) (
  input  logic clock50,
  input  logic reset_n,
  input  logic i_run,
  output logic o_bclk,
  output logic o_fall
);
  localparam int            DW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_bclk;
  logic          w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (!i_run) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_bclk = r_bclk;
  // Registered outputs change on the same edge that drops aud_bclk.
  assign o_fall = i_run && w_wrap && r_bclk;
endmodule

// File: rtl/audio_dac_serializer.sv
// Mono I2S serializer: captures one attenuated sample per frame and sends it MSB-first in both slots.
module audio_dac_serializer #(
  parameter int BCLK_DIV  = audio_pkg::BCLK_DIV_DEFAULT,
  parameter int SLOT_BITS = audio_pkg::SLOT_BITS
) (
  input logic                   clock50,
  input logic                   reset_n,
  audio_dac_serializer_if.slave bus
);
  import audio_pkg::*;

  localparam int            SW        = $clog2(SLOT_BITS);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] DATA_END  = SW'(SAMPLE_W);

  state_e              r_state;
  state_e              w_next;
  logic                w_run;
  logic                w_bclk;
  logic                w_fall;
  logic                w_boundary;
  logic                w_capture;
  logic [SW-1:0]       r_slot;
  logic                r_lrck;
  logic                r_dat;
  logic                r_fs;
  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_shift;

  assign w_run = (r_state == RUN);

  audio_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clock50 (clock50),
    .reset_n (reset_n),
    .i_run   (w_run),
    .o_bclk  (w_bclk),
    .o_fall  (w_fall)
  );

  assign w_boundary = w_fall && (r_slot == SLOT_LAST) && r_lrck;

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en) begin
          w_next    = RUN;
          w_capture = 1'b1;
        end
      end
      RUN: begin
        if (w_boundary) begin
          if (bus.en) w_capture = 1'b1;
          else        w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
      r_lrck <= 1'b0;
    end else if (!w_run) begin
      r_slot <= '0;
      r_lrck <= 1'b0;
    end else if (w_fall) begin
      if (r_slot == SLOT_LAST) begin
        r_slot <= '0;
        r_lrck <= ~r_lrck;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  // One-bit I2S delay: the fall leaving slot 0 presents the MSB, slots 17..31 stay at 0.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      r_hold  <= '0;
      r_shift <= '0;
      r_dat   <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_fs <= w_capture;
      if (w_capture) r_hold <= attenuate(bus.sample_in, bus.vol_shift, bus.mute);
      if (!w_run) begin
        r_shift <= '0;
        r_dat   <= 1'b0;
      end else if (w_fall) begin
        if (r_slot == '0) begin
          {r_dat, r_shift} <= {r_hold, 1'b0};
        end else if (r_slot < DATA_END) begin
          {r_dat, r_shift} <= {r_shift, 1'b0};
        end else begin
          r_dat <= 1'b0;
        end
      end
    end
  end

  assign bus.aud_bclk    = w_bclk;
  assign bus.aud_daclrck = r_lrck;
  assign bus.aud_dacdat  = r_dat;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: per-cycle frame model plus en-drop and mid-frame reset sequences.
module tb_audio_dac_serializer;
  typedef struct packed {
    logic [15:0] sample;
    logic [2:0]  vol;
    logic        mute;
    logic [15:0] expWord;
    logic        toggle;
  } vec_t;

  logic clock50;
  logic resetN;
  int   checkCount;
  int   passCount;

  audio_dac_serializer_if bus();

  audio_dac_serializer #(
    .BCLK_DIV  (8),
    .SLOT_BITS (32)
  ) dut (
    .clock50 (clock50),
    .reset_n (resetN),
    .bus     (bus)
  );

  initial clock50 = 1'b0;
  always #10 clock50 = ~clock50;

  task automatic stepCycle();
    @(posedge clock50);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] sample,
                               input logic [2:0] vol, input logic mute);
    bus.en        = en;
    bus.sample_in = sample;
    bus.vol_shift = vol;
    bus.mute      = mute;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [3:0] outBits();
    return {bus.aud_bclk, bus.aud_daclrck, bus.aud_dacdat, bus.frame_start};
  endfunction

  // Entered at cycle 0 of a frame; returns at cycle 0 of the following frame.
  task automatic readFrame(input logic [15:0] expWord, input vec_t nextVec,
                           input logic toggle, input int dropEnAt,
                           output logic [15:0] leftWord, output logic [15:0] rightWord,
                           output int timingErr);
    int   slot;
    int   s;
    logic expDat;
    logic expBclk;
    logic expLrck;
    logic expFs;
    leftWord  = '0;
    rightWord = '0;
    timingErr = 0;
    for (int c = 0; c < 1024; c++) begin
      slot    = c / 16;
      s       = slot % 32;
      expDat  = (s >= 1 && s <= 16) ? expWord[16 - s] : 1'b0;
      expBclk = ((c / 8) % 2) == 1;
      expLrck = (c >= 512);
      expFs   = (c == 0);
      if (outBits() !== {expBclk, expLrck, expDat, expFs}) timingErr++;
      if (c % 16 == 8) begin
        if (slot >= 1 && slot <= 16)       leftWord[16 - slot]  = bus.aud_dacdat;
        else if (slot >= 33 && slot <= 48) rightWord[48 - slot] = bus.aud_dacdat;
      end
      if (toggle && (c % 100 == 50) && c < 900) bus.sample_in = ~bus.sample_in;
      if (c == dropEnAt) bus.en = 1'b0;
      if (c == 900) applyStimulus(bus.en, nextVec.sample, nextVec.vol, nextVec.mute);
      stepCycle();
    end
  endtask

  initial begin
    vec_t        vecs [8];
    vec_t        tailVec;
    vec_t        restartVec;
    vec_t        nextV;
    logic [15:0] leftW;
    logic [15:0] rightW;
    int          tErr;
    int          idleErr;

    checkCount = 0;
    passCount  = 0;
    vecs[0] = '{sample: 16'h8001, vol: 3'd0, mute: 1'b0, expWord: 16'h8001, toggle: 1'b0};
    vecs[1] = '{sample: 16'h7FFF, vol: 3'd3, mute: 1'b0, expWord: 16'h0FFF, toggle: 1'b0};
    vecs[2] = '{sample: 16'h7FFF, vol: 3'd3, mute: 1'b1, expWord: 16'h0000, toggle: 1'b0};
    vecs[3] = '{sample: 16'h8000, vol: 3'd7, mute: 1'b0, expWord: 16'hFF00, toggle: 1'b0};
    vecs[4] = '{sample: 16'hA5A5, vol: 3'd1, mute: 1'b0, expWord: 16'hD2D2, toggle: 1'b1};
    vecs[5] = '{sample: 16'hF0F0, vol: 3'd4, mute: 1'b0, expWord: 16'hFF0F, toggle: 1'b0};
    vecs[6] = '{sample: 16'hFFFF, vol: 3'd7, mute: 1'b0, expWord: 16'hFFFF, toggle: 1'b0};
    vecs[7] = '{sample: 16'h0001, vol: 3'd1, mute: 1'b0, expWord: 16'h0000, toggle: 1'b0};
    tailVec    = '{sample: 16'h8001, vol: 3'd0, mute: 1'b0, expWord: 16'h8001, toggle: 1'b0};
    restartVec = '{sample: 16'h0F0F, vol: 3'd0, mute: 1'b0, expWord: 16'h0F0F, toggle: 1'b0};

    resetN = 1'b0;
    applyStimulus(1'b0, 16'h0000, 3'd0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("reset outputs", 32'(outBits()), 32'h0);

    applyStimulus(1'b1, vecs[0].sample, vecs[0].vol, vecs[0].mute);
    stepCycle();
    checkOutput("outputs held in reset with en", 32'(outBits()), 32'h0);

    resetN = 1'b1;
    stepCycle();
    checkOutput("frame_start on RUN entry", 32'(bus.frame_start), 32'h1);

    for (int i = 0; i < 8; i++) begin
      nextV = (i < 7) ? vecs[i + 1] : tailVec;
      readFrame(vecs[i].expWord, nextV, vecs[i].toggle, -1, leftW, rightW, tErr);
      checkOutput($sformatf("vec%0d left word", i), 32'(leftW), 32'(vecs[i].expWord));
      checkOutput($sformatf("vec%0d right word", i), 32'(rightW), 32'(vecs[i].expWord));
      checkOutput($sformatf("vec%0d timing errors", i), 32'(tErr), 32'h0);
      checkOutput($sformatf("vec%0d frame_start spacing", i), 32'(bus.frame_start), 32'h1);
    end

    // en falls at cycle 300: the frame must still finish, then the block sits idle.
    readFrame(16'h8001, tailVec, 1'b0, 300, leftW, rightW, tErr);
    checkOutput("en-drop left word", 32'(leftW), 32'h8001);
    checkOutput("en-drop right word", 32'(rightW), 32'h8001);
    checkOutput("en-drop timing errors", 32'(tErr), 32'h0);
    idleErr = 0;
    for (int c = 1024; c < 2000; c++) begin
      if (outBits() !== 4'b0000) idleErr++;
      stepCycle();
    end
    checkOutput("idle cycles with active outputs", 32'(idleErr), 32'h0);

    applyStimulus(1'b1, 16'h3C5A, 3'd0, 1'b0);
    stepCycle();
    checkOutput("restart frame_start", 32'(bus.frame_start), 32'h1);
    readFrame(16'h3C5A, restartVec, 1'b0, -1, leftW, rightW, tErr);
    checkOutput("restart left word", 32'(leftW), 32'h3C5A);
    checkOutput("restart right word", 32'(rightW), 32'h3C5A);
    checkOutput("restart timing errors", 32'(tErr), 32'h0);
    checkOutput("restart frame_start spacing", 32'(bus.frame_start), 32'h1);

    // Reset lands at cycle 700 while aud_bclk is high.
    for (int c = 0; c < 700; c++) stepCycle();
    checkOutput("bclk high before reset", 32'(bus.aud_bclk), 32'h1);
    resetN = 1'b0;
    #2;
    checkOutput("async reset outputs", 32'(outBits()), 32'h0);
    stepCycle();
    checkOutput("outputs stay low in reset", 32'(outBits()), 32'h0);
    resetN = 1'b1;
    stepCycle();
    checkOutput("frame_start after reset release", 32'(bus.frame_start), 32'h1);
    readFrame(16'h0F0F, restartVec, 1'b0, -1, leftW, rightW, tErr);
    checkOutput("post-reset left word", 32'(leftW), 32'h0F0F);
    checkOutput("post-reset right word", 32'(rightW), 32'h0F0F);
    checkOutput("post-reset timing errors", 32'(tErr), 32'h0);
    checkOutput("post-reset frame_start spacing", 32'(bus.frame_start), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
